// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU (add, AND, XOR, iterative unsigned multiply)
// with registered results and a single-cycle out_valid pulse per completed op.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (ready only while idle)
//   s, A, B           op select (00 add, 01 AND, 10 XOR, 11 mul) and operands
//   out_valid         one-cycle pulse when Y/Z/carry/O carry a new result
//   Y                 add/AND/XOR result (0 after multiply)
//   Z                 2*WIDTH-bit product (0 after other ops)
//   carry, O          unsigned carry-out and signed overflow of add
//
// Optional build macro: ALU_SEQ_EARLY_TERM_EN
//   When defined, the multiply stops as soon as no multiplier bits remain.
module alu_seq #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         s,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               out_valid,
   output logic [WIDTH-1:0]   Y,
   output logic [2*WIDTH-1:0] Z,
   output logic               carry,
   output logic               O
);

   typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

   state_t state_q;
   state_t state_d;

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;

   logic [2*WIDTH-1:0] acc_nxt;
   logic [2*WIDTH-1:0] mcand_nxt;
   logic [WIDTH-1:0]   mplier_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               mul_done;

   logic               accept;
   logic               is_add;
   logic               is_and;
   logic               is_xor;
   logic               is_mul;
   logic [WIDTH:0]     sum;
   logic               ovf;

   assign accept = in_valid & in_ready;

   assign is_add = (s == 2'b00);
   assign is_and = (s == 2'b01);
   assign is_xor = (s == 2'b10);
   assign is_mul = (s == 2'b11);

   assign sum = {1'b0, A} + {1'b0, B};
   assign ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                (sum[WIDTH-1] != A[WIDTH-1]);

   // One shift-add step of the multiplier datapath.
   always_comb begin
      acc_nxt    = mplier[0] ? acc + mcand : acc;
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
      cnt_nxt    = cnt + 1'b1;
`ifdef ALU_SEQ_EARLY_TERM_EN
      // Remaining multiplier bits all zero: further steps add nothing.
      mul_done   = (cnt_nxt == CNT_W'(WIDTH)) ||
                   (mplier_nxt == '0);
`else
      mul_done   = (cnt_nxt == CNT_W'(WIDTH));
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept && is_mul) state_d = MUL;
         MUL:  if (mul_done)         state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs.
   always_comb begin
      in_ready = (state_q == IDLE);
   end

   // Datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         Y         <= '0;
         Z         <= '0;
         carry     <= 1'b0;
         O         <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
      end else begin
         out_valid <= 1'b0;
         if (accept) begin
            unique case (1'b1)
               is_add: begin
                  Y         <= sum[WIDTH-1:0];
                  carry     <= sum[WIDTH];
                  O         <= ovf;
                  Z         <= '0;
                  out_valid <= 1'b1;
               end
               is_and: begin
                  Y         <= A & B;
                  carry     <= 1'b0;
                  O         <= 1'b0;
                  Z         <= '0;
                  out_valid <= 1'b1;
               end
               is_xor: begin
                  Y         <= A ^ B;
                  carry     <= 1'b0;
                  O         <= 1'b0;
                  Z         <= '0;
                  out_valid <= 1'b1;
               end
               is_mul: begin
                  mcand  <= {{WIDTH{1'b0}}, A};
                  mplier <= B;
                  acc    <= '0;
                  cnt    <= '0;
               end
               default: ;
            endcase
         end else if (state_q == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt_nxt;
            if (mul_done) begin
               Z         <= acc_nxt;
               Y         <= '0;
               carry     <= 1'b0;
               O         <= 1'b0;
               out_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq
// (WIDTH=8 main instance plus a WIDTH=16 instance).
module tb_alu_seq;

   logic        clk;
   logic        rst;

   logic        in_valid;
   logic        in_ready;
   logic [1:0]  s;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        out_valid;
   logic [7:0]  Y;
   logic [15:0] Z;
   logic        carry;
   logic        O;

   logic        w_in_valid;
   logic        w_in_ready;
   logic [1:0]  w_s;
   logic [15:0] w_A;
   logic [15:0] w_B;
   logic        w_out_valid;
   logic [15:0] w_Y;
   logic [31:0] w_Z;
   logic        w_carry;
   logic        w_O;

   int n_cmp;
   int n_bad;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .s(s), .A(A), .B(B),
      .out_valid(out_valid), .Y(Y), .Z(Z),
      .carry(carry), .O(O)
   );

   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid), .in_ready(w_in_ready),
      .s(w_s), .A(w_A), .B(w_B),
      .out_valid(w_out_valid), .Y(w_Y), .Z(w_Z),
      .carry(w_carry), .O(w_O)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ALU_SEQ_EARLY_TERM_EN
   localparam int LAT_0A03 = 3;
   localparam int LAT_5500 = 2;
`else
   localparam int LAT_0A03 = 9;
   localparam int LAT_5500 = 9;
`endif

   // Present one op for a single edge; returns #1 after the accept edge.
   task automatic issue(input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b);
      in_valid = 1'b1; s = op; A = a; B = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Cycles from accept edge until out_valid is seen (1 = after accept edge).
   task automatic wait_ov(output int n);
      n = 1;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++;
      if ({out_valid, Y, Z, carry, O, in_ready} !== {1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset: got ov=%b Y=%h Z=%h c=%b O=%b rdy=%b want 0/00/0000/0/0/1",
                  out_valid, Y, Z, carry, O, in_ready);
      end
      n_cmp++;
      if ({w_out_valid, w_Y, w_Z, w_carry, w_O, w_in_ready} !== {1'b0, 16'h0, 32'h0, 3'b001}) begin
         n_bad++;
         $display("FAIL reset16: got ov=%b Y=%h Z=%h rdy=%b want 0/0000/00000000/1",
                  w_out_valid, w_Y, w_Z, w_in_ready);
      end
   endtask

   task automatic test_add_carry();
      int n;
      issue(2'b00, 8'hC8, 8'h64);
      wait_ov(n);
      n_cmp++;
      if (n !== 1) begin
         n_bad++;
         $display("FAIL add_carry_lat: got %0d want 1", n);
      end
      n_cmp++;
      if ({Y, carry, O, Z} !== {8'h2C, 1'b1, 1'b0, 16'h0}) begin
         n_bad++;
         $display("FAIL add_carry: got Y=%h c=%b O=%b Z=%h want 2c/1/0/0000",
                  Y, carry, O, Z);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL add_pulse: got ov=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; s = 2'b00; A = 8'h64; B = 8'h64;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, Y, carry, O} !== {1'b1, 8'hC8, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL add_ovf: got ov=%b Y=%h c=%b O=%b want 1/c8/0/1",
                  out_valid, Y, carry, O);
      end
      s = 2'b01; A = 8'hF0; B = 8'h3C;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, Y, carry, O} !== {1'b1, 8'h30, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL b2b_and: got ov=%b Y=%h c=%b O=%b want 1/30/0/0",
                  out_valid, Y, carry, O);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_idle: got ov=%b want 0", out_valid);
      end
   endtask

   task automatic test_xor_mul();
      int n;
      int busy_bad;
      issue(2'b10, 8'hF0, 8'h3C);
      n_cmp++;
      if ({out_valid, Y, Z} !== {1'b1, 8'hCC, 16'h0}) begin
         n_bad++;
         $display("FAIL xor: got ov=%b Y=%h Z=%h want 1/cc/0000", out_valid, Y, Z);
      end
      // Multiply, then hold a pending add during the MUL phase.
      in_valid = 1'b1; s = 2'b11; A = 8'hFF; B = 8'hFF;
      @(posedge clk); #1;
      s = 2'b00; A = 8'h01; B = 8'h02;
      n = 1;
      busy_bad = 0;
      while (!out_valid && n < 40) begin
         if (in_ready !== 1'b0 || Y !== 8'hCC) busy_bad++;
         @(posedge clk); #1;
         n++;
      end
      n_cmp++;
      if (busy_bad !== 0) begin
         n_bad++;
         $display("FAIL mul_busy: got %0d bad cycles want 0", busy_bad);
      end
      n_cmp++;
      if (n !== 9) begin
         n_bad++;
         $display("FAIL mul_lat: got %0d want 9", n);
      end
      n_cmp++;
      if ({Z, Y, carry, O, in_ready} !== {16'hFE01, 8'h00, 3'b001}) begin
         n_bad++;
         $display("FAIL mul_ff: got Z=%h Y=%h c=%b O=%b rdy=%b want fe01/00/0/0/1",
                  Z, Y, carry, O, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, Y, Z} !== {1'b1, 8'h03, 16'h0}) begin
         n_bad++;
         $display("FAIL held_add: got ov=%b Y=%h Z=%h want 1/03/0000",
                  out_valid, Y, Z);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int stray;
      issue(2'b11, 8'h12, 8'h34);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if ({out_valid, Y, Z, carry, O, in_ready} !== {1'b0, 8'h0, 16'h0, 3'b001}) begin
         n_bad++;
         $display("FAIL rst_mid: got ov=%b Y=%h Z=%h c=%b O=%b rdy=%b want 0/00/0000/0/0/1",
                  out_valid, Y, Z, carry, O, in_ready);
      end
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) stray++;
      end
      n_cmp++;
      if (stray !== 0) begin
         n_bad++;
         $display("FAIL rst_abort: got %0d stray out_valid want 0", stray);
      end
      issue(2'b11, 8'h12, 8'h34);
      wait_ov(n);
      n_cmp++;
      if ({n[7:0], Z, Y} !== {8'd9, 16'h03A8, 8'h00}) begin
         n_bad++;
         $display("FAIL mul_after_rst: got lat=%0d Z=%h Y=%h want 9/03a8/00",
                  n, Z, Y);
      end
   endtask

   task automatic test_early_term();
      int n;
      issue(2'b11, 8'h0A, 8'h03);
      wait_ov(n);
      n_cmp++;
      if ({n[7:0], Z} !== {LAT_0A03[7:0], 16'h001E}) begin
         n_bad++;
         $display("FAIL mul_0a03: got lat=%0d Z=%h want %0d/001e",
                  n, Z, LAT_0A03);
      end
      issue(2'b11, 8'h55, 8'h00);
      wait_ov(n);
      n_cmp++;
      if ({n[7:0], Z} !== {LAT_5500[7:0], 16'h0000}) begin
         n_bad++;
         $display("FAIL mul_5500: got lat=%0d Z=%h want %0d/0000",
                  n, Z, LAT_5500);
      end
   endtask

   task automatic test_width16();
      int n;
      w_in_valid = 1'b1; w_s = 2'b11; w_A = 16'hFFFF; w_B = 16'hFFFF;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      n = 1;
      while (!w_out_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      n_cmp++;
      if ({n[7:0], w_Z, w_Y} !== {8'd17, 32'hFFFE0001, 16'h0}) begin
         n_bad++;
         $display("FAIL mul16: got lat=%0d Z=%h Y=%h want 17/fffe0001/0000",
                  n, w_Z, w_Y);
      end
      w_in_valid = 1'b1; w_s = 2'b00; w_A = 16'hFFFF; w_B = 16'h0001;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      n_cmp++;
      if ({w_out_valid, w_Y, w_carry, w_O, w_Z} !== {1'b1, 16'h0, 1'b1, 1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL add16: got ov=%b Y=%h c=%b O=%b Z=%h want 1/0000/1/0/0",
                  w_out_valid, w_Y, w_carry, w_O, w_Z);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      in_valid = 1'b0; s = 2'b00; A = '0; B = '0;
      w_in_valid = 1'b0; w_s = 2'b00; w_A = '0; w_B = '0;
      test_reset();
      test_add_carry();
      test_back_to_back();
      test_xor_mul();
      test_reset_mid();
      test_early_term();
      test_width16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
